// File: rtl/inst_fetch_queue_if.sv
// Fetch-stage bundle: redirect/halt control, imem request/response, and the decode-facing queue head.
interface inst_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              pc_halt;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        input  pc_halt, redirect_valid, redirect_pc, imem_req_ready,
        input  imem_rsp_valid, imem_rdata, inst_ready,
        output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, occupancy
    );

    modport slave (
        output pc_halt, redirect_valid, redirect_pc, imem_req_ready,
        output imem_rsp_valid, imem_rdata, inst_ready,
        input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, occupancy
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Decoupled fetch: issues in-order imem requests and queues {pc, inst}; a response is visible at the head one cycle later.
// Backpressure via credits: requests stop once queued + outstanding reaches DEPTH; redirect flushes and squashes in-flight responses.
module inst_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_queue_if.master fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CW1   = CNT_W + 1;
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic [OUT_W-1:0]  disc_q, disc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic              run_q;
    entry_t            mem_q [DEPTH];

    logic              req_vld, req_fire, rsp_take, enq, deq;
    logic [CW1-1:0]    credit_used;
    logic [ADDR_W-1:0] redir_pc;

    assign redir_pc    = fq.redirect_pc & ~ADDR_W'(3);
    assign credit_used = {1'b0, count_q} + CW1'(out_q);

    // run_q keeps the request line low while reset is held and for the first edge after release.
    assign req_vld  = run_q & ~fq.pc_halt & ~fq.redirect_valid
                    & (out_q < OUT_W'(MAX_OUT)) & (credit_used < CW1'(DEPTH));
    assign req_fire = req_vld & fq.imem_req_ready;
    assign rsp_take = fq.imem_rsp_valid & (out_q != '0);
    assign enq      = rsp_take & (disc_q == '0) & ~fq.redirect_valid;
    assign deq      = (count_q != '0) & fq.inst_ready & ~fq.redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        disc_d     = disc_q;
        out_d      = out_q + OUT_W'(req_fire) - OUT_W'(rsp_take);
        count_d    = count_q + CNT_W'(enq) - CNT_W'(deq);
        if (req_fire)                 fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        if (rsp_take && disc_q != '0) disc_d     = disc_q - OUT_W'(1);
        if (enq) begin
            tail_d    = tail_q + PTR_W'(1);
            resp_pc_d = resp_pc_q + ADDR_W'(4);
        end
        if (deq)                      head_d     = head_q + PTR_W'(1);
        // Every request still in flight after this cycle belongs to the old stream.
        if (fq.redirect_valid) begin
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            count_d    = '0;
            tail_d     = head_q;
            disc_d     = out_q - OUT_W'(rsp_take);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            out_q      <= '0;
            disc_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            run_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            run_q      <= 1'b1;
            if (enq) mem_q[tail_q] <= {resp_pc_q, fq.imem_rdata};
        end
    end

    assign fq.imem_req_valid = req_vld;
    assign fq.imem_addr      = fetch_pc_q;
    assign fq.inst_valid     = (count_q != '0);
    assign fq.inst           = mem_q[head_q].inst;
    assign fq.inst_pc        = mem_q[head_q].pc;
    assign fq.occupancy      = count_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: in-order memory model plus a scoreboard of expected {pc, inst} pushed at request acceptance.
module tb_inst_fetch_queue;
    localparam int AW = 32;
    localparam int IW = 32;
    localparam int DP = 4;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_queue_if #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DP)) bus ();
    inst_fetch_queue_if #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DP)) bus2 ();

    inst_fetch_queue #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DP), .MAX_OUT(2), .RESET_PC(32'h0))
        dut (.clk(clk), .rst(rst), .fq(bus.master));
    inst_fetch_queue #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DP), .MAX_OUT(2), .RESET_PC(32'hFFFF_FFF8))
        dut2 (.clk(clk), .rst(rst), .fq(bus2.master));

    int n_cmp = 0;
    int n_err = 0;
    int cyc, fires, deqs;
    logic [AW-1:0] pend_addr [$];
    int            pend_due  [$];
    exp_t          sb        [$];
    logic [AW-1:0] exp_addr, last_fire_addr, first_deq_pc;

    logic          c_halt, c_redir, c_inst_rdy, c_req_rdy, c_hold;
    logic [AW-1:0] c_redir_pc;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 32'hA5C3_0F96;
    endfunction

    // One clock: drive after the rising edge, observe and account at the falling edge.
    task automatic step();
        exp_t          e;
        logic [AW-1:0] a;
        @(posedge clk); #1;
        cyc++;
        bus.pc_halt        = c_halt;
        bus.redirect_valid = c_redir;
        bus.redirect_pc    = c_redir_pc;
        bus.inst_ready     = c_inst_rdy;
        bus.imem_req_ready = c_req_rdy;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rdata     = '0;
        if (!c_hold && pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            a = pend_addr.pop_front();
            void'(pend_due.pop_front());
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rdata     = mem_word(a);
        end
        @(negedge clk);
        if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL deq_unexpected: got pc=%h inst=%h, required no dequeue", bus.inst_pc, bus.inst);
            end else begin
                e = sb.pop_front();
                if (bus.inst_pc !== e.pc || bus.inst !== e.inst) begin
                    n_err++;
                    $display("FAIL deq_data: got pc=%h inst=%h, required pc=%h inst=%h",
                             bus.inst_pc, bus.inst, e.pc, e.inst);
                end
                if (deqs == 0) first_deq_pc = bus.inst_pc;
                deqs++;
            end
        end
        if (bus.redirect_valid) begin
            sb.delete();
            exp_addr = c_redir_pc & ~32'h3;
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            n_cmp++;
            if (bus.imem_addr !== exp_addr) begin
                n_err++;
                $display("FAIL req_addr: got %h, required %h", bus.imem_addr, exp_addr);
            end
            pend_addr.push_back(bus.imem_addr);
            pend_due.push_back(cyc + 1);
            sb.push_back({bus.imem_addr, mem_word(bus.imem_addr)});
            exp_addr       = bus.imem_addr + 32'd4;
            last_fire_addr = bus.imem_addr;
            fires++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        {c_halt, c_redir, c_inst_rdy, c_req_rdy, c_hold} = '0;
        c_redir_pc = '0;
        {bus.pc_halt, bus.redirect_valid, bus.inst_ready, bus.imem_req_ready, bus.imem_rsp_valid} = '0;
        {bus2.pc_halt, bus2.redirect_valid, bus2.inst_ready, bus2.imem_req_ready, bus2.imem_rsp_valid} = '0;
        bus.redirect_pc = '0; bus.imem_rdata = '0;
        bus2.redirect_pc = '0; bus2.imem_rdata = '0;
        pend_addr.delete(); pend_due.delete(); sb.delete();
        exp_addr = '0; fires = 0; deqs = 0; cyc = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain();
        c_halt = 1'b1; c_hold = 1'b0; c_redir = 1'b0; c_inst_rdy = 1'b1;
        for (int i = 0; i < 30 && (sb.size() != 0 || pend_addr.size() != 0); i++) step();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries never dequeued, required 0", sb.size());
        end
        c_halt = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 5;
        if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b, required 0", bus.imem_req_valid); end
        if (bus.inst_valid !== 1'b0)     begin n_err++; $display("FAIL rst_inst_valid: got %b, required 0", bus.inst_valid); end
        if (bus.occupancy !== 3'd0)      begin n_err++; $display("FAIL rst_occupancy: got %0d, required 0", bus.occupancy); end
        if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
            n_err++; $display("FAIL rst_head: got inst=%h pc=%h, required 0/0", bus.inst, bus.inst_pc);
        end
        if (bus.imem_addr !== 32'h0 || bus2.imem_addr !== 32'hFFFF_FFF8) begin
            n_err++; $display("FAIL rst_pc: got %h/%h, required 0/fffffff8", bus.imem_addr, bus2.imem_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        c_req_rdy = 1'b1; c_inst_rdy = 1'b1;
        repeat (16) step();
        n_cmp += 2;
        if (deqs < 8) begin n_err++; $display("FAIL stream_deqs: got %0d, required at least 8", deqs); end
        if (first_deq_pc !== 32'h0) begin n_err++; $display("FAIL stream_first_pc: got %h, required 0", first_deq_pc); end
        drain();
    endtask

    task automatic test_full();
        do_reset();
        c_req_rdy = 1'b1; c_inst_rdy = 1'b0;
        repeat (10) step();
        n_cmp += 3;
        if (fires != 4)                  begin n_err++; $display("FAIL full_fires: got %0d, required 4", fires); end
        if (bus.occupancy !== 3'd4)      begin n_err++; $display("FAIL full_occupancy: got %0d, required 4", bus.occupancy); end
        if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL full_req_valid: got %b, required 0", bus.imem_req_valid); end
        c_inst_rdy = 1'b1;
        repeat (4) step();
        n_cmp += 2;
        if (deqs != 4)  begin n_err++; $display("FAIL full_drain_deqs: got %0d, required 4", deqs); end
        if (fires < 5)  begin n_err++; $display("FAIL full_resume: got %0d fires, required at least 5", fires); end
        drain();
    endtask

    task automatic test_redirect();
        do_reset();
        c_req_rdy = 1'b1; c_inst_rdy = 1'b1;
        c_redir = 1'b1; c_redir_pc = 32'h8;
        step();
        c_redir = 1'b0; c_hold = 1'b1;
        repeat (4) step();
        n_cmp += 2;
        if (fires != 2 || pend_addr.size() != 2) begin
            n_err++; $display("FAIL redir_setup: got %0d fires %0d pending, required 2/2", fires, pend_addr.size());
        end
        if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL redir_maxout: got %b, required 0", bus.imem_req_valid); end
        c_redir = 1'b1; c_redir_pc = 32'h103;
        step();
        c_redir = 1'b0;
        step();
        n_cmp++;
        if (bus.occupancy !== 3'd0) begin n_err++; $display("FAIL redir_occupancy: got %0d, required 0", bus.occupancy); end
        c_hold = 1'b0;
        repeat (10) step();
        n_cmp++;
        if (deqs == 0 || first_deq_pc !== 32'h100) begin
            n_err++; $display("FAIL redir_first_pc: got %h after %0d deqs, required 00000100", first_deq_pc, deqs);
        end
        drain();
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        c_req_rdy = 1'b1; c_inst_rdy = 1'b0;
        for (int i = 0; i < 20 && bus.occupancy == 3'd0; i++) step();
        c_hold = 1'b1;
        for (int i = 0; i < 10 && pend_addr.size() != 2; i++) step();
        n_cmp++;
        if (pend_addr.size() != 2 || bus.occupancy == 3'd0) begin
            n_err++; $display("FAIL same_setup: got %0d pending occ=%0d, required 2 pending occ>0", pend_addr.size(), bus.occupancy);
        end
        c_hold = 1'b0; c_inst_rdy = 1'b1; c_redir = 1'b1; c_redir_pc = 32'h200;
        step();
        n_cmp++;
        if (!(bus.imem_rsp_valid && bus.inst_valid && !bus.imem_req_valid)) begin
            n_err++; $display("FAIL same_cycle: got rsp=%b inst_valid=%b req=%b, required 1/1/0",
                              bus.imem_rsp_valid, bus.inst_valid, bus.imem_req_valid);
        end
        c_redir = 1'b0;
        step();
        n_cmp++;
        if (bus.occupancy !== 3'd0) begin n_err++; $display("FAIL same_occupancy: got %0d, required 0", bus.occupancy); end
        repeat (10) step();
        n_cmp++;
        if (deqs == 0 || first_deq_pc !== 32'h200) begin
            n_err++; $display("FAIL same_first_pc: got %h after %0d deqs, required 00000200", first_deq_pc, deqs);
        end
        drain();
    endtask

    task automatic test_halt();
        int f0;
        do_reset();
        c_req_rdy = 1'b1; c_inst_rdy = 1'b0; c_hold = 1'b1;
        for (int i = 0; i < 10 && pend_addr.size() != 2; i++) step();
        c_halt = 1'b1; c_hold = 1'b0;
        f0 = fires;
        repeat (5) step();
        n_cmp += 3;
        if (fires != f0)                 begin n_err++; $display("FAIL halt_fires: got %0d, required %0d", fires, f0); end
        if (bus.occupancy !== 3'd2)      begin n_err++; $display("FAIL halt_occupancy: got %0d, required 2", bus.occupancy); end
        if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL halt_req_valid: got %b, required 0", bus.imem_req_valid); end
        c_redir = 1'b1; c_redir_pc = 32'h40;
        step();
        c_redir = 1'b0;
        step();
        n_cmp++;
        if (fires != f0 || bus.occupancy !== 3'd0) begin
            n_err++; $display("FAIL halt_redirect: got fires=%0d occ=%0d, required %0d/0", fires, bus.occupancy, f0);
        end
        c_halt = 1'b0; c_inst_rdy = 1'b1;
        for (int i = 0; i < 10 && fires == f0; i++) step();
        n_cmp++;
        if (fires == f0 || last_fire_addr !== 32'h40) begin
            n_err++; $display("FAIL halt_resume: got addr %h (fires %0d), required 00000040", last_fire_addr, fires - f0);
        end
        drain();
    endtask

    task automatic test_wrap_and_async_reset();
        logic [AW-1:0] q2 [$];
        logic [AW-1:0] got [$];
        logic [AW-1:0] a;
        do_reset();
        bus2.imem_req_ready = 1'b1;
        bus2.inst_ready     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bus2.imem_rsp_valid = 1'b0;
            if (q2.size() != 0) begin
                a = q2.pop_front();
                bus2.imem_rsp_valid = 1'b1;
                bus2.imem_rdata     = mem_word(a);
            end
            @(negedge clk);
            if (bus2.imem_req_valid) begin
                q2.push_back(bus2.imem_addr);
                got.push_back(bus2.imem_addr);
            end
        end
        bus2.imem_rsp_valid = 1'b0;
        n_cmp += 3;
        if (got.size() < 3) begin
            n_err++; $display("FAIL wrap_count: got %0d requests, required at least 3", got.size());
        end else if (got[0] !== 32'hFFFF_FFF8 || got[1] !== 32'hFFFF_FFFC || got[2] !== 32'h0) begin
            n_err++; $display("FAIL wrap_addr: got %h %h %h, required fffffff8 fffffffc 00000000", got[0], got[1], got[2]);
        end
        if (bus2.inst_pc !== 32'hFFFF_FFF8 || bus2.inst !== mem_word(32'hFFFF_FFF8)) begin
            n_err++; $display("FAIL wrap_head: got pc=%h inst=%h, required pc=fffffff8 inst=%h",
                              bus2.inst_pc, bus2.inst, mem_word(32'hFFFF_FFF8));
        end
        if (bus2.occupancy !== 3'd4) begin n_err++; $display("FAIL wrap_occupancy: got %0d, required 4", bus2.occupancy); end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (bus2.occupancy !== 3'd0 || bus2.inst_valid !== 1'b0 || bus2.imem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got occ=%0d inst_valid=%b req=%b, required 0/0/0",
                              bus2.occupancy, bus2.inst_valid, bus2.imem_req_valid);
        end
        do_reset();
    endtask

    initial begin
        rst = 1'b0;
        {bus.pc_halt, bus.redirect_valid, bus.inst_ready, bus.imem_req_ready, bus.imem_rsp_valid} = '0;
        {bus2.pc_halt, bus2.redirect_valid, bus2.inst_ready, bus2.imem_req_ready, bus2.imem_rsp_valid} = '0;
        bus.redirect_pc = '0; bus.imem_rdata = '0;
        bus2.redirect_pc = '0; bus2.imem_rdata = '0;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_redirect_same_cycle();
        test_halt();
        test_wrap_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
